// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver and transmitter.
package uart_pkg;

    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_e;

    localparam int unsigned TUSER_FRAME_ERR  = 0;
    localparam int unsigned TUSER_PARITY_ERR = 1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter producing a half-bit or full-bit sample strobe; shared by rx and tx.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic half_i,
    output logic strobe_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || cnt_q == FullCnt) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign strobe_o = half_i ? (cnt_q == HalfCnt) : (cnt_q == FullCnt);

endmodule

// File: rtl/uart_rx_axis.sv
// Oversampling UART receiver with an AXI-Stream output register and per-character error flags.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each strobe.
module uart_rx_axis
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned PARITY_MODE  = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  rx_i,
    output logic [DATA_WIDTH-1:0] mst_axis_tdata_o,
    output logic [1:0]            mst_axis_tuser_o,
    output logic                  mst_axis_tvalid_o,
    input  logic                  mst_axis_tready_i,
    output logic                  overrun_o,
    output logic                  busy_o
);

    localparam parity_e ParMode = parity_e'(2'(PARITY_MODE));

    rx_state_e             state_q, state_d;
    logic                  rx_meta_q, rx_s_q;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  ferr_q, ferr_d, perr_q, perr_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [1:0]            tuser_q, tuser_d;
    logic                  tvalid_q, tvalid_d, overrun_q, overrun_d;
    logic                  timer_clear, strobe, fire, bit_s, complete;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear_i (timer_clear),
        .half_i  (state_q == START),
        .strobe_o(strobe)
    );

`ifdef UART_RX_MAJORITY_EN
    // Decision one cycle after the strobe, once the strobe+1 sample exists.
    logic rx_h1_q, rx_h2_q, strobe_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_h1_q  <= 1'b1;
            rx_h2_q  <= 1'b1;
            strobe_q <= 1'b0;
        end else begin
            rx_h1_q  <= rx_s_q;
            rx_h2_q  <= rx_h1_q;
            strobe_q <= strobe;
        end
    end

    assign fire  = strobe_q;
    assign bit_s = maj3(rx_h2_q, rx_h1_q, rx_s_q);
`else
    assign fire  = strobe;
    assign bit_s = rx_s_q;
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        ferr_d      = ferr_q;
        perr_d      = perr_q;
        timer_clear = 1'b0;
        complete    = 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_clear = 1'b1;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                // Restart the bit period at mid-start so later strobes land mid-bit.
                if (strobe) timer_clear = 1'b1;
                if (fire) begin
                    if (bit_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        ferr_d    = 1'b0;
                        perr_d    = 1'b0;
                    end
                end
            end
            DATA: begin
                if (fire) begin
                    data_d = {bit_s, data_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == 4'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (ParMode == PAR_NONE) ? STOP : PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (fire) begin
                    perr_d  = (^data_q ^ bit_s) ^ (ParMode == PAR_ODD);
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fire) begin
                    if (!bit_s) ferr_d = 1'b1;
                    if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                        complete = 1'b1;
                        state_d  = bit_s ? IDLE : WAIT_HIGH;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            WAIT_HIGH: begin
                timer_clear = 1'b1;
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tdata_d   = tdata_q;
        tuser_d   = tuser_q;
        tvalid_d  = tvalid_q;
        overrun_d = 1'b0;
        if (tvalid_q && mst_axis_tready_i) tvalid_d = 1'b0;
        if (complete) begin
            if (!tvalid_q || mst_axis_tready_i) begin
                tdata_d                   = data_q;
                tuser_d[TUSER_FRAME_ERR]  = ferr_d;
                tuser_d[TUSER_PARITY_ERR] = perr_q;
                tvalid_d                  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            data_q    <= '0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            tdata_q   <= '0;
            tuser_q   <= '0;
            tvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            tdata_q   <= tdata_d;
            tuser_q   <= tuser_d;
            tvalid_q  <= tvalid_d;
            overrun_q <= overrun_d;
        end
    end

    assign mst_axis_tdata_o  = tdata_q;
    assign mst_axis_tuser_o  = tuser_q;
    assign mst_axis_tvalid_o = tvalid_q;
    assign overrun_o         = overrun_q;
    assign busy_o            = (state_q != IDLE);

endmodule
